obi_copy_master: RTL and testbench

//  OBI initiator (manager) that copies a block of 32-bit words from a source to a destination address.

---
 rtl/obi_copy_master.sv | 163 ++++++++++++++++
 tb/tb_obi_copy_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_copy_master.sv
// OBI manager that copies a block of 32-bit words from src to dst, one
// transaction at a time: read a word, write it back out, move to the next.
module obi_copy_master #(
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // command / status
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    // OBI manager port
    output logic             obi_req_o,
    input  logic             obi_gnt_i,
    output logic [31:0]      obi_addr_o,
    output logic             obi_we_o,
    output logic [3:0]       obi_be_o,
    output logic [31:0]      obi_wdata_o,
    input  logic             obi_rvalid_i,
    input  logic [31:0]      obi_rdata_i
);

    // one extra bit so TIMEOUT_CYC itself is representable
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RSP,
        WR_REQ,
        WR_RSP,
        FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       src_q, src_d;
    logic [31:0]       dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [31:0]       data_q, data_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;

    // state and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // next-state: command decode, bus handshakes, response timeout
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        err_d   = err_q;
        // timeout counter only advances while waiting on a response, so any
        // other state leaves it cleared for the next response phase
        tmo_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d = src_addr_i;
                    dst_d = dst_addr_i;
                    rem_d = len_i;
                    err_d = 1'b0;
                    if (len_i == '0) begin
                        state_d = FINISH;
                    end else if ((src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end

            RD_REQ: begin
                if (obi_gnt_i) state_d = RD_RSP;
            end

            RD_RSP: begin
                if (obi_rvalid_i) begin
                    data_d  = obi_rdata_i;
                    state_d = WR_REQ;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            WR_REQ: begin
                if (obi_gnt_i) state_d = WR_RSP;
            end

            WR_RSP: begin
                if (obi_rvalid_i) begin
                    rem_d   = rem_q - 1'b1;
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    state_d = (rem_q == LEN_W'(1)) ? FINISH : RD_REQ;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // outputs decoded straight from the state register so an async reset
    // drops req in the same cycle; address/data held constant until gnt
    always_comb begin
        obi_req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
        obi_we_o    = (state_q == WR_REQ);
        obi_be_o    = 4'hF;
        obi_addr_o  = '0;
        obi_wdata_o = '0;
        if (state_q == RD_REQ) obi_addr_o = src_q;
        if (state_q == WR_REQ) begin
            obi_addr_o  = dst_q;
            obi_wdata_o = data_q;
        end
        busy_o = (state_q == RD_REQ) || (state_q == RD_RSP) ||
                 (state_q == WR_REQ) || (state_q == WR_RSP);
        done_o = (state_q == FINISH);
        err_o  = err_q;
    end

endmodule

// File: tb/tb_obi_copy_master.sv
// Bench for obi_copy_master: memory-backed OBI responder with programmable
// grant delay / response latency, plus a transaction-level copy model.
module tb_obi_copy_master;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, err_o;
    logic        obi_req_o, obi_we_o;
    logic        obi_gnt_i = 1'b0;
    logic        obi_rvalid_i = 1'b0;
    logic [31:0] obi_addr_o, obi_wdata_o;
    logic [31:0] obi_rdata_i = '0;
    logic [3:0]  obi_be_o;

    obi_copy_master #(.LEN_W(16), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .start_i(start_i), .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- responder / memory ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        txq[$];
    logic [31:0] mem [logic [31:0]];
    int          r_gdly, r_rlat;
    bit          r_nrsp;
    int          wait_cnt, rsp_cnt;
    logic [31:0] pend;
    bit          held;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    task automatic resp_reset(input int g, input int rl, input bit nrsp);
        r_gdly = g; r_rlat = rl; r_nrsp = nrsp;
        wait_cnt = 0; rsp_cnt = 0; held = 0;
        mem.delete();
        txq.delete();
    endtask

    // called once per cycle at the negedge, after outputs have been sampled
    task automatic resp_step();
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'hDEAD_BEEF;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0 && !r_nrsp) begin
                obi_rvalid_i = 1'b1;
                obi_rdata_i  = pend;
            end
        end else if (obi_req_o) begin
            chk("be", obi_be_o, 32'hF);
            if (held) begin
                chk("hold_addr", obi_addr_o, h_addr);
                chk("hold_we", obi_we_o, h_we);
                chk("hold_wdata", obi_wdata_o, h_wdata);
            end
            if (wait_cnt >= r_gdly) begin
                obi_gnt_i = 1'b1;
                txq.push_back('{obi_we_o, obi_addr_o, obi_wdata_o});
                if (obi_we_o) mem[obi_addr_o] = obi_wdata_o;
                else          pend = rd_mem(obi_addr_o);
                rsp_cnt  = r_rlat;
                wait_cnt = 0;
                held     = 0;
            end else begin
                wait_cnt++;
                held    = 1;
                h_addr  = obi_addr_o;
                h_we    = obi_we_o;
                h_wdata = obi_wdata_o;
            end
        end
    endtask

    // ---------------- reference model ----------------
    // cycle (counted from the start cycle = 0) in which done pulses
    function automatic int model_done_cyc(input logic [31:0] s, input logic [31:0] d,
                                          input int n, input int g, input int rl, input bit nrsp);
        if (n == 0) return 1;
        if (s[1:0] != 0 || d[1:0] != 0) return 1;
        if (nrsp) return g + TMO + 2;             // req cycles, then TMO response cycles
        return n * 2 * (g + 1 + rl) + 1;          // read+write, each (g+1) req + rl rsp
    endfunction

    function automatic bit model_err(input logic [31:0] s, input logic [31:0] d,
                                     input int n, input bit nrsp);
        if (n == 0) return 0;
        if (s[1:0] != 0 || d[1:0] != 0) return 1;
        return nrsp;
    endfunction

    task automatic run_copy(input string nm, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input int g, input int rl, input bit nrsp,
                            input bit poke, input int exp_cyc, input bit exp_err);
        txn_t exq[$];
        int   done_cnt = 0;
        int   done_at = -1;
        bit   copying;
        copying = (n != 0) && (s[1:0] == 0) && (d[1:0] == 0);
        if (copying) begin
            for (int i = 0; i < (nrsp ? 1 : int'(n)); i++) begin
                logic [31:0] sa, da;
                sa = s + 32'(4 * i);
                da = d + 32'(4 * i);
                exq.push_back('{1'b0, sa, 32'h0});
                if (!nrsp) exq.push_back('{1'b1, da, pat(sa)});
            end
        end
        resp_reset(g, rl, nrsp);
        start_i = 1'b1; src_addr_i = s; dst_addr_i = d; len_i = n;
        for (int cyc = 1; cyc < exp_cyc + 40; cyc++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (poke && copying && cyc == 3) begin
                // ignored: would flag an error if it were accepted
                start_i = 1'b1; src_addr_i = 32'h0000_0001; len_i = 16'd7;
            end
            if (cyc == 1) chk({nm, "_busy1"}, busy_o, copying);
            if (done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
                chk({nm, "_busy_at_done"}, busy_o, 1'b0);
            end
            resp_step();
            if (done_at >= 0 && cyc >= done_at + 2) break;
        end
        start_i = 1'b0;
        chk({nm, "_done_cyc"}, done_at, exp_cyc);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_err"}, err_o, exp_err);
        chk({nm, "_ntxn"}, txq.size(), exq.size());
        for (int i = 0; i < exq.size() && i < txq.size(); i++) begin
            chk({nm, "_txn_we"}, txq[i].we, exq[i].we);
            chk({nm, "_txn_addr"}, txq[i].addr, exq[i].addr);
            if (exq[i].we) chk({nm, "_txn_wdata"}, txq[i].data, exq[i].data);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        string       nm;
        logic [31:0] s, d;
        logic [15:0] n;
        int          g, rl;
        bit          nrsp;
        int          exp_cyc;
        bit          exp_err;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{"zero_wait",  32'h8000_0000, 32'h8000_0100, 16'd4, 0, 1, 1'b0, 17, 1'b0};
        vt[1] = '{"gnt_dly3",   32'h8000_0000, 32'h8000_0100, 16'd4, 3, 1, 1'b0, 41, 1'b0};
        vt[2] = '{"len0",       32'h8000_0000, 32'h8000_0100, 16'd0, 0, 1, 1'b0, 1,  1'b0};
        vt[3] = '{"src_mis",    32'h8000_0002, 32'h8000_0100, 16'd5, 0, 1, 1'b0, 1,  1'b1};
        vt[4] = '{"dst_mis",    32'h8000_0000, 32'h8000_0101, 16'd5, 0, 1, 1'b0, 1,  1'b1};
        vt[5] = '{"timeout",    32'h8000_0000, 32'h8000_0100, 16'd2, 0, 1, 1'b1, 18, 1'b1};
        vt[6] = '{"after_tmo",  32'h8000_0000, 32'h8000_0100, 16'd1, 0, 1, 1'b0, 5,  1'b0};
        vt[7] = '{"wrap",       32'hFFFF_FFFC, 32'h0000_0100, 16'd2, 0, 1, 1'b0, 9,  1'b0};
        vt[8] = '{"slow_rsp",   32'h0000_0040, 32'h0000_0080, 16'd3, 1, 3, 1'b0, 31, 1'b0};
        vt[9] = '{"len0_mis",   32'h8000_0002, 32'h8000_0100, 16'd0, 0, 1, 1'b0, 1,  1'b0};

        // reset state
        repeat (2) @(negedge clk_i);
        chk("rst_req", obi_req_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_addr", obi_addr_o, 32'h0);
        chk("rst_we", obi_we_o, 1'b0);
        chk("rst_wdata", obi_wdata_o, 32'h0);
        chk("rst_be", obi_be_o, 32'hF);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 10; i++) begin
            run_copy(vt[i].nm, vt[i].s, vt[i].d, vt[i].n, vt[i].g, vt[i].rl,
                     vt[i].nrsp, 1'b0, vt[i].exp_cyc, vt[i].exp_err);
            if (vt[i].nrsp) begin
                // stray gnt/rvalid with nothing outstanding must be ignored
                obi_gnt_i = 1'b1; obi_rvalid_i = 1'b1;
                @(negedge clk_i);
                obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0;
                @(negedge clk_i);
                chk("stray_busy", busy_o, 1'b0);
                chk("stray_done", done_o, 1'b0);
                chk("stray_req", obi_req_o, 1'b0);
                chk("stray_err_kept", err_o, 1'b1);
            end
        end

        // reset in the middle of a write request
        begin
            bit hit = 0;
            resp_reset(0, 1, 1'b0);
            start_i = 1'b1; src_addr_i = 32'h0000_1000; dst_addr_i = 32'h0000_2000; len_i = 16'd3;
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(negedge clk_i);
                start_i = 1'b0;
                if (obi_req_o && obi_we_o) begin
                    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0;
                    rst_ni = 1'b0;
                    #1;
                    chk("mid_rst_req", obi_req_o, 1'b0);
                    chk("mid_rst_busy", busy_o, 1'b0);
                    hit = 1;
                    break;
                end
                resp_step();
            end
            chk("mid_rst_reached_wr", hit, 1'b1);
            @(negedge clk_i);
            chk("mid_rst_done", done_o, 1'b0);
            rst_ni = 1'b1;
            @(negedge clk_i);
            chk("post_rst_done", done_o, 1'b0);
            run_copy("post_rst", 32'h0000_1000, 32'h0000_2000, 16'd3, 0, 1, 1'b0, 1'b0, 13, 1'b0);
        end

        // randomized copies checked against the model
        for (int k = 0; k < 12; k++) begin
            logic [31:0] s, d;
            int n, g, rl;
            bit poke;
            s    = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
            d    = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
            n    = $urandom_range(1, 5);
            g    = $urandom_range(0, 3);
            rl   = $urandom_range(1, 3);
            poke = 1'($urandom_range(0, 1));
            run_copy("rand", s, d, 16'(n), g, rl, 1'b0, poke,
                     model_done_cyc(s, d, n, g, rl, 1'b0), model_err(s, d, n, 1'b0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
